time_ascii_tx: RTL and testbench

Formats a time snapshot (hour, minute, second, centisecond) from the watch/stopwatch as the ASCII line "HH:MM:SS.CC" plus an optional CR LF, and pushes it byte by byte into the UART TX FIFO. It is the transmit-side counterpart of the RX command decoder, which pops bytes from the RX FIFO and turns them into control pulses. A one-cycle request snapshots the inputs, and the block then drains the message under FIFO back-pressure.

---
 rtl/uart_ascii_pkg.sv | 26 ++
 rtl/time_ascii_tx_if.sv | 34 +++
 rtl/bin2ascii2.sv | 28 ++
 rtl/time_ascii_tx.sv | 127 ++++++++++++
 tb/tb_time_ascii_tx.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ascii_pkg.sv
// -----------------------------------------------------------------------------
// uart_ascii_pkg
// Shared definitions for the ASCII UART helpers (TX time formatter and the
// RX command decoder): ASCII character constants, the message-length/index
// sizing and the formatter FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_ascii_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Longest message is "HH:MM:SS.CC" + CR LF.
    localparam int MSG_LEN_MAX = 13;
    localparam int IDX_W       = $clog2(MSG_LEN_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/time_ascii_tx_if.sv
// -----------------------------------------------------------------------------
// time_ascii_tx_if
// Bundles the request/time inputs and the FIFO push outputs of time_ascii_tx.
//   send_req  : single-cycle transmit request
//   hour/min/sec/cs : time snapshot fields (binary)
//   fifo_full : TX FIFO full flag
//   push/wdata: FIFO write strobe and byte
//   busy/done : message in progress / end-of-message pulse
// Modports: slave = formatter side, master = requester/FIFO side.
// -----------------------------------------------------------------------------
interface time_ascii_tx_if;

    logic       send_req;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] cs;
    logic       fifo_full;
    logic       push;
    logic [7:0] wdata;
    logic       busy;
    logic       done;

    modport slave (
        input  send_req, hour, min, sec, cs, fifo_full,
        output push, wdata, busy, done
    );

    modport master (
        output send_req, hour, min, sec, cs, fifo_full,
        input  push, wdata, busy, done
    );

endinterface

// File: rtl/bin2ascii2.sv
// -----------------------------------------------------------------------------
// bin2ascii2
// Combinational conversion of a 7-bit binary value to two ASCII decimal
// digits. Values above 99 saturate to "99".
//   i_val   in  7  binary value
//   o_tens  out 8  ASCII tens digit
//   o_ones  out 8  ASCII ones digit
// -----------------------------------------------------------------------------
module bin2ascii2
    import uart_ascii_pkg::*;
(
    input  logic [6:0] i_val,
    output logic [7:0] o_tens,
    output logic [7:0] o_ones
);

    logic [6:0] w_sat;
    logic [6:0] w_tens;
    logic [6:0] w_ones;

    assign w_sat  = (i_val > 7'd99) ? 7'd99 : i_val;
    assign w_tens = w_sat / 7'd10;
    assign w_ones = w_sat % 7'd10;

    assign o_tens = ASCII_0 + {1'b0, w_tens};
    assign o_ones = ASCII_0 + {1'b0, w_ones};

endmodule

// File: rtl/time_ascii_tx.sv
// -----------------------------------------------------------------------------
// time_ascii_tx
// On a one-cycle request, snapshots hour/min/sec/cs and streams the ASCII
// line "HH:MM:SS.CC" (optionally followed by CR LF) into the UART TX FIFO,
// one byte per cycle whenever the FIFO is not full.
// Parameters:
//   CRLF : 1 appends CR LF (13 bytes), 0 omits them (11 bytes)
//   SEP  : separator between HH/MM and MM/SS
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of time_ascii_tx_if (request, time, FIFO push side)
// -----------------------------------------------------------------------------
module time_ascii_tx
    import uart_ascii_pkg::*;
#(
    parameter bit         CRLF = 1'b1,
    parameter logic [7:0] SEP  = ASCII_COLON
)
(
    input  logic            clk,
    input  logic            rst,
    time_ascii_tx_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = CRLF ? IDX_W'(12) : IDX_W'(10);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [4:0]       r_hour;
    logic [5:0]       r_min;
    logic [5:0]       r_sec;
    logic [6:0]       r_cs;

    logic             w_push;
    logic [7:0]       w_char;
    logic [7:0]       w_h1, w_h0, w_m1, w_m0, w_s1, w_s0, w_c1, w_c0;

    bin2ascii2 u_hour (.i_val({2'b00, r_hour}), .o_tens(w_h1), .o_ones(w_h0));
    bin2ascii2 u_min  (.i_val({1'b0, r_min}),   .o_tens(w_m1), .o_ones(w_m0));
    bin2ascii2 u_sec  (.i_val({1'b0, r_sec}),   .o_tens(w_s1), .o_ones(w_s0));
    bin2ascii2 u_cs   (.i_val(r_cs),            .o_tens(w_c1), .o_ones(w_c0));

    // Push is combinational so back-pressure stalls within the same cycle,
    // and an asynchronous reset drops it immediately through r_state.
    assign w_push = (r_state == ST_SEND) && !bus.fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Snapshot is taken only when leaving IDLE, so requests during a
    // message neither queue nor disturb the bytes being sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
            r_cs   <= '0;
        end else if (r_state == ST_IDLE && bus.send_req) begin
            r_idx  <= '0;
            r_hour <= bus.hour;
            r_min  <= bus.min;
            r_sec  <= bus.sec;
            r_cs   <= bus.cs;
        end else if (w_push) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    always_comb begin
        w_char = 8'h00;
        case (r_idx)
            4'd0:    w_char = w_h1;
            4'd1:    w_char = w_h0;
            4'd2:    w_char = SEP;
            4'd3:    w_char = w_m1;
            4'd4:    w_char = w_m0;
            4'd5:    w_char = SEP;
            4'd6:    w_char = w_s1;
            4'd7:    w_char = w_s0;
            4'd8:    w_char = ASCII_DOT;
            4'd9:    w_char = w_c1;
            4'd10:   w_char = w_c0;
            4'd11:   w_char = ASCII_CR;
            4'd12:   w_char = ASCII_LF;
            default: w_char = 8'h00;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        bus.push  = w_push;
        bus.wdata = 8'h00;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.send_req) begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                bus.busy  = 1'b1;
                bus.wdata = w_char;
                if (w_push && r_idx == LAST_IDX) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_time_ascii_tx.sv
// -----------------------------------------------------------------------------
// tb_time_ascii_tx
// Self-checking bench for time_ascii_tx. Two instances (CRLF=1 and CRLF=0)
// share the same stimulus; a transaction-level model per instance predicts
// push/wdata/busy/done every cycle, and directed scenarios pin literal bytes.
// -----------------------------------------------------------------------------
module tb_time_ascii_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_req = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic [6:0] cs = '0;
    logic       fifo_full = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    time_ascii_tx_if if0 ();
    time_ascii_tx_if if1 ();

    assign if0.send_req = send_req;  assign if1.send_req = send_req;
    assign if0.hour = hour;          assign if1.hour = hour;
    assign if0.min = min;            assign if1.min = min;
    assign if0.sec = sec;            assign if1.sec = sec;
    assign if0.cs = cs;              assign if1.cs = cs;
    assign if0.fifo_full = fifo_full; assign if1.fifo_full = fifo_full;

    time_ascii_tx #(.CRLF(1'b1), .SEP(8'h3A)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    time_ascii_tx #(.CRLF(1'b0), .SEP(8'h3A)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       o_push  [2];
    logic [7:0] o_wdata [2];
    logic       o_busy  [2];
    logic       o_done  [2];
    assign o_push[0] = if0.push;   assign o_push[1] = if1.push;
    assign o_wdata[0] = if0.wdata; assign o_wdata[1] = if1.wdata;
    assign o_busy[0] = if0.busy;   assign o_busy[1] = if1.busy;
    assign o_done[0] = if0.done;   assign o_done[1] = if1.done;

    // Model state: 0 idle, 1 sending, 2 done cycle.
    int         m_phase [2] = '{0, 0};
    logic [7:0] m_q     [2][$];
    logic [7:0] cap     [2][$];
    int         done_cnt [2] = '{0, 0};
    int         done_cyc   = 0;
    int         first_push = -1;
    int         req_cyc    = 0;

    logic [7:0] lit [4][13] = '{
        '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A},
        '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33, 8'h2E, 8'h30, 8'h34, 8'h0D, 8'h0A},
        '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h39, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A},
        '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A}
    };

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Expected message from the decimal formatting rules.
    function automatic void build(input int d, input int h, input int m, input int s, input int c);
        int cc;
        cc = (c > 99) ? 99 : c;
        m_q[d].delete();
        m_q[d].push_back(8'(48 + h / 10));  m_q[d].push_back(8'(48 + h % 10));
        m_q[d].push_back(8'h3A);
        m_q[d].push_back(8'(48 + m / 10));  m_q[d].push_back(8'(48 + m % 10));
        m_q[d].push_back(8'h3A);
        m_q[d].push_back(8'(48 + s / 10));  m_q[d].push_back(8'(48 + s % 10));
        m_q[d].push_back(8'h2E);
        m_q[d].push_back(8'(48 + cc / 10)); m_q[d].push_back(8'(48 + cc % 10));
        if (d == 0) begin
            m_q[d].push_back(8'h0D);
            m_q[d].push_back(8'h0A);
        end
    endfunction

    // Compare every cycle, then advance the model with the inputs that the
    // next rising edge will sample (inputs only change just after posedge).
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("rst_push", {31'd0, o_push[d]}, 0);
                chk("rst_busy", {31'd0, o_busy[d]}, 0);
                chk("rst_done", {31'd0, o_done[d]}, 0);
                m_phase[d] = 0;
                m_q[d].delete();
            end else begin
                chk("push", {31'd0, o_push[d]}, {31'd0, (m_phase[d] == 1) && !fifo_full});
                chk("busy", {31'd0, o_busy[d]}, {31'd0, m_phase[d] != 0});
                chk("done", {31'd0, o_done[d]}, {31'd0, m_phase[d] == 2});
                if (o_push[d] && m_phase[d] == 1 && m_q[d].size() > 0)
                    chk("wdata", {24'd0, o_wdata[d]}, {24'd0, m_q[d][0]});
                if (o_push[d]) begin
                    cap[d].push_back(o_wdata[d]);
                    if (d == 0 && first_push < 0) first_push = cyc;
                end
                if (o_done[d]) begin
                    done_cnt[d]++;
                    if (d == 0) done_cyc = cyc;
                end
                case (m_phase[d])
                    0: if (send_req) begin
                        build(d, int'(hour), int'(min), int'(sec), int'(cs));
                        m_phase[d] = 1;
                    end
                    1: if (!fifo_full) begin
                        void'(m_q[d].pop_front());
                        if (m_q[d].size() == 0) m_phase[d] = 2;
                    end
                    default: m_phase[d] = 0;
                endcase
            end
        end
    end

    task automatic clear_caps();
        cap[0].delete();
        cap[1].delete();
        first_push = -1;
    endtask

    task automatic send();
        @(posedge clk); #1;
        send_req = 1'b1;
        req_cyc  = cyc;
        @(posedge clk); #1;
        send_req = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour = 5'(h); min = 6'(m); sec = 6'(s); cs = 7'(c);
    endtask

    task automatic wait_done(input int prev, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk); #1;
            if (done_cnt[0] > prev) ok = 1'b1;
        end
        if (!ok) timeout(nm);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_cap(input int n, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); #1;
            if (cap[0].size() >= n) ok = 1'b1;
        end
        if (!ok) timeout(nm);
    endtask

    task automatic check_cap(input int d, input int li, input int len, input string nm);
        chk({nm, "_len"}, cap[d].size(), len);
        for (int i = 0; i < len && i < cap[d].size(); i++)
            chk(nm, {24'd0, cap[d][i]}, {24'd0, lit[li][i]});
    endtask

    initial begin
        int p;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_push",  {31'd0, if0.push}, 0);
        chk("reset_wdata", {24'd0, if0.wdata}, 0);
        chk("reset_busy",  {31'd0, if0.busy}, 0);
        chk("reset_done",  {31'd0, if1.done}, 0);
        rst = 1'b0;

        // Nominal 12:34:56.78
        clear_caps();
        set_time(12, 34, 56, 78);
        p = done_cnt[0];
        send();
        wait_done(p, "nominal");
        chk("latency", first_push, req_cyc + 1);
        chk("done_after_last", done_cyc - first_push, 13);
        check_cap(0, 0, 13, "nominal_crlf");
        check_cap(1, 0, 11, "nominal_nocrlf");

        // Back-pressure for 5 cycles after the 3rd byte
        clear_caps();
        p = done_cnt[0];
        send();
        wait_cap(3, "bp_cap3");
        @(posedge clk); #1;
        fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_held", cap[0].size(), 3);
        fifo_full = 1'b0;
        wait_done(p, "backpressure");
        chk("bp_done_delay", done_cyc - first_push, 18);
        check_cap(0, 0, 13, "bp_bytes");

        // Request while busy is ignored
        clear_caps();
        set_time(12, 34, 56, 78);
        p = done_cnt[0];
        send();
        repeat (3) @(posedge clk);
        #1;
        set_time(1, 2, 3, 4);
        send_req = 1'b1;
        @(posedge clk); #1;
        send_req = 1'b0;
        wait_done(p, "busy_req");
        repeat (10) @(negedge clk);
        #1;
        check_cap(0, 0, 13, "busy_orig");
        chk("busy_no_second", done_cnt[0], p + 1);
        clear_caps();
        p = done_cnt[0];
        send();
        wait_done(p, "after_done");
        check_cap(0, 1, 13, "new_snapshot");

        // Saturation of cs, both CRLF settings
        clear_caps();
        set_time(0, 0, 9, 120);
        p = done_cnt[0];
        send();
        wait_done(p, "saturate");
        check_cap(1, 2, 11, "sat_nocrlf");
        check_cap(0, 2, 13, "sat_crlf");

        // Reset mid-message
        clear_caps();
        set_time(12, 34, 56, 78);
        send();
        wait_cap(6, "rst_cap6");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_push0", {31'd0, if0.push}, 0);
        chk("rst_mid_push1", {31'd0, if1.push}, 0);
        chk("rst_mid_busy", {31'd0, if0.busy}, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_caps();
        set_time(23, 59, 59, 99);
        p = done_cnt[0];
        send();
        wait_done(p, "after_reset");
        check_cap(0, 3, 13, "restart");

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            fifo_full = ($urandom_range(0, 3) == 0);
            send_req  = ($urandom_range(0, 7) == 0);
            set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 127)));
        end
        @(posedge clk); #1;
        send_req  = 1'b0;
        fifo_full = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("final_idle", {31'd0, if0.busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
